mips_uc_top: RTL and testbench

- Minimal single-cycle MIPS-subset microcontroller: 32-bit core, internal instruction ROM, internal data RAM, and one memory-mapped 32-bit bidirectional GPIO port (port_io).
- Top-level block of the microcontroller. The board drives buttons on port_io[2:0]; the other pins are driven by firmware.

---
 rtl/mips_uc_top.sv | 157 +++++++++++++++
 tb/tb_mips_uc_top.sv | 130 +++++++++++++
 2 files changed

// File: rtl/mips_uc_top.sv
// Single-cycle MIPS-subset microcontroller: ROM fetch, 32 GPRs, data RAM and one memory-mapped GPIO port.
// Define MIPS_UC_PORT_ENABLE_EN to add the PORT_EN register at 0x80000008.
module mips_uc_top #(
    parameter int    IMEM_WORDS = 256,
    parameter int    DMEM_WORDS = 256,
    parameter string IMEM_INIT  = "program.hex"
) (
    input  logic        sys_clk,
    input  logic        rst_sync,
    inout  wire  [31:0] port_io
);
    localparam int IAW = $clog2(IMEM_WORDS);
    localparam int DAW = $clog2(DMEM_WORDS);

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_BEQ  = 6'h04, OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_ANDI = 6'h0C, OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E, OP_LUI  = 6'h0F, OP_LW   = 6'h23, OP_SW   = 6'h2B;
    localparam logic [5:0] FN_SLL   = 6'h00, FN_SRL  = 6'h02, FN_ADDU = 6'h21, FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24, FN_OR   = 6'h25, FN_XOR  = 6'h26, FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A, FN_SLTU = 6'h2B;

    // I/O registers are matched on word address (addr[31:2]).
    localparam logic [29:0] IO_DATA = 30'h2000_0000;
    localparam logic [29:0] IO_CFG  = 30'h2000_0001;
`ifdef MIPS_UC_PORT_ENABLE_EN
    localparam logic [29:0] IO_EN   = 30'h2000_0002;
`endif

    logic [31:0] imem [IMEM_WORDS];
    logic [31:0] dmem [DMEM_WORDS];
    logic [31:0] regs [32];

    logic [31:0] pc, instr, pc_plus4, br_tgt, j_tgt, next_pc;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs_idx, rt_idx, rd_idx, shamt, wb_idx;
    logic [15:0] imm;
    logic [31:0] imm_s, imm_z, rs_val, rt_val, addr, ld_val, wb_val;
    logic        wb_en, st_en, ram_we, io_we;
    logic [31:0] port_out, port_cfg, port_en, pin_oe, pin_rd;
    logic        unused_addr_lsb;

    assign instr    = imem[pc[IAW+1:2]];
    assign opcode   = instr[31:26];
    assign rs_idx   = instr[25:21];
    assign rt_idx   = instr[20:16];
    assign rd_idx   = instr[15:11];
    assign shamt    = instr[10:6];
    assign funct    = instr[5:0];
    assign imm      = instr[15:0];
    assign imm_s    = {{16{imm[15]}}, imm};
    assign imm_z    = {16'h0000, imm};

    assign rs_val   = (rs_idx == 5'd0) ? 32'h0 : regs[rs_idx];
    assign rt_val   = (rt_idx == 5'd0) ? 32'h0 : regs[rt_idx];

    assign pc_plus4 = pc + 32'd4;
    assign br_tgt   = pc_plus4 + (imm_s << 2);
    assign j_tgt    = {pc_plus4[31:28], instr[25:0], 2'b00};

    assign addr            = rs_val + imm_s;
    assign unused_addr_lsb = ^addr[1:0];
    assign ram_we          = st_en && !addr[31];
    assign io_we           = st_en && addr[31];

    // Pins are driven only when configured as outputs (and enabled, if PORT_EN exists).
    assign pin_oe = ~port_cfg & port_en;
    assign pin_rd = ((port_cfg & port_io) | (~port_cfg & port_out)) & port_en;

    for (genvar i = 0; i < 32; i++) begin : g_pin
        assign port_io[i] = pin_oe[i] ? port_out[i] : 1'bz;
    end

    always_comb begin
        ld_val = 32'h0;
        if (!addr[31]) begin
            ld_val = dmem[addr[DAW+1:2]];
        end else if (addr[31:2] == IO_DATA) begin
            ld_val = pin_rd;
        end else if (addr[31:2] == IO_CFG) begin
            ld_val = port_cfg;
`ifdef MIPS_UC_PORT_ENABLE_EN
        end else if (addr[31:2] == IO_EN) begin
            ld_val = port_en;
`endif
        end
    end

    always_comb begin
        wb_en   = 1'b0;
        wb_idx  = rt_idx;
        wb_val  = 32'h0;
        st_en   = 1'b0;
        next_pc = pc_plus4;
        case (opcode)
            OP_RTYPE: begin
                wb_en  = 1'b1;
                wb_idx = rd_idx;
                case (funct)
                    FN_ADDU: wb_val = rs_val + rt_val;
                    FN_SUBU: wb_val = rs_val - rt_val;
                    FN_AND:  wb_val = rs_val & rt_val;
                    FN_OR:   wb_val = rs_val | rt_val;
                    FN_XOR:  wb_val = rs_val ^ rt_val;
                    FN_NOR:  wb_val = ~(rs_val | rt_val);
                    FN_SLT:  wb_val = {31'h0, $signed(rs_val) < $signed(rt_val)};
                    FN_SLTU: wb_val = {31'h0, rs_val < rt_val};
                    FN_SLL:  wb_val = rt_val << shamt;
                    FN_SRL:  wb_val = rt_val >> shamt;
                    default: wb_en  = 1'b0;
                endcase
            end
            OP_ADDIU: begin wb_en = 1'b1; wb_val = rs_val + imm_s; end
            OP_SLTI:  begin wb_en = 1'b1; wb_val = {31'h0, $signed(rs_val) < $signed(imm_s)}; end
            OP_ANDI:  begin wb_en = 1'b1; wb_val = rs_val & imm_z; end
            OP_ORI:   begin wb_en = 1'b1; wb_val = rs_val | imm_z; end
            OP_XORI:  begin wb_en = 1'b1; wb_val = rs_val ^ imm_z; end
            OP_LUI:   begin wb_en = 1'b1; wb_val = {imm, 16'h0000}; end
            OP_LW:    begin wb_en = 1'b1; wb_val = ld_val; end
            OP_SW:    st_en = 1'b1;
            OP_BEQ:   if (rs_val == rt_val) next_pc = br_tgt;
            OP_BNE:   if (rs_val != rt_val) next_pc = br_tgt;
            OP_J:     next_pc = j_tgt;
            default:  ;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!rst_sync) begin
            pc       <= 32'h0;
            port_out <= 32'h0;
            port_cfg <= 32'hFFFF_FFFF;
            for (int i = 0; i < 32; i++) regs[i] <= 32'h0;
        end else begin
            pc <= next_pc;
            if (wb_en && wb_idx != 5'd0) regs[wb_idx] <= wb_val;
            if (io_we && addr[31:2] == IO_DATA) port_out <= rt_val;
            if (io_we && addr[31:2] == IO_CFG)  port_cfg <= rt_val;
        end
    end

`ifdef MIPS_UC_PORT_ENABLE_EN
    always_ff @(posedge sys_clk) begin
        if (!rst_sync) begin
            port_en <= 32'h0;
        end else if (io_we && addr[31:2] == IO_EN) begin
            port_en <= rt_val;
        end
    end
`else
    assign port_en = 32'hFFFF_FFFF;
`endif

    // RAM keeps its contents across reset; only the store of a reset cycle is dropped.
    always_ff @(posedge sys_clk) begin
        if (rst_sync && ram_we) dmem[addr[DAW+1:2]] <= rt_val;
    end
endmodule

// File: tb/tb_mips_uc_top.sv
// Directed bench for mips_uc_top: loads a hand-assembled program into the ROM and checks GPIO, RAM, ALU,
// control flow and reset behaviour against hand-computed values.
module tb_mips_uc_top;
    logic        sys_clk = 1'b0;
    logic        rst_sync;
    logic [2:0]  btn;
    wire  [31:0] port_io;
    int          n_pass  = 0;
    int          n_total = 0;
    logic [31:0] prog [23];

    assign port_io[2:0] = btn;

    mips_uc_top #(
        .IMEM_WORDS(256),
        .DMEM_WORDS(256),
        .IMEM_INIT ("")
    ) dut (
        .sys_clk (sys_clk),
        .rst_sync(rst_sync),
        .port_io (port_io)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] gpr_nonzero();
        logic [31:0] n = 32'h0;
        for (int i = 0; i < 32; i++) if (dut.regs[i] !== 32'h0) n++;
        return n;
    endfunction

    initial begin
        prog = '{
            32'h3C088000,  // 0  lui   $t0,0x8000
            32'h24090007,  // 1  addiu $t1,$0,7
            32'hAD090004,  // 2  sw    $t1,4($t0)      cfg = 7
            32'h3C0AA5A5,  // 3  lui   $t2,0xA5A5
            32'h354AA5A0,  // 4  ori   $t2,$t2,0xA5A0
            32'hAD0A0000,  // 5  sw    $t2,0($t0)      port_out
            32'h8D0B0000,  // 6  lw    $t3,0($t0)
            32'h8D0B0000,  // 7  lw    $t3,0($t0)
            32'h3C0C1234,  // 8  lui   $t4,0x1234
            32'h358C5678,  // 9  ori   $t4,$t4,0x5678
            32'hAC0C0040,  // 10 sw    $t4,0x40($0)
            32'h8C100040,  // 11 lw    $s0,0x40($0)
            32'h02108823,  // 12 subu  $s1,$s0,$s0
            32'h0010902A,  // 13 slt   $s2,$0,$s0
            32'h240D0005,  // 14 addiu $t5,$0,5
            32'h25ADFFFF,  // 15 loop: addiu $t5,$t5,-1
            32'hFC0E7000,  // 16 illegal opcode, rt=rd=$t6
            32'h15A0FFFD,  // 17 bne   $t5,$0,loop
            32'h08000015,  // 18 j     21
            32'h240E0001,  // 19 addiu $t6,$0,1 (skipped)
            32'h240E0002,  // 20 addiu $t6,$0,2 (skipped)
            32'h240F0077,  // 21 addiu $t7,$0,0x77
            32'h1000FFFF   // 22 beq   $0,$0,22
        };
        for (int i = 0; i < 256; i++) dut.imem[i] = (i < 23) ? prog[i] : 32'h0;

        btn      = 3'b101;
        rst_sync = 1'b0;
        tick(3);
        chk("reset_pc",      dut.pc,        32'h0);
        chk("reset_gpr",     gpr_nonzero(), 32'h0);
        chk("reset_cfg",     dut.port_cfg,  32'hFFFF_FFFF);
        chk("reset_pin_oe",  dut.pin_oe,    32'h0);
        chk("reset_fetch",   dut.instr,     32'h3C088000);

        rst_sync = 1'b1;
        tick(6);
        chk("gpio_cfg",      dut.port_cfg,  32'h0000_0007);
        chk("gpio_pin_oe",   dut.pin_oe,    32'hFFFF_FFF8);
        chk("gpio_out_pins", {3'b000, port_io[31:3]}, 32'h14B4B4B4);

        tick(1);
        chk("gpio_in_101",   dut.regs[11],  32'hA5A5_A5A5);
        btn = 3'b010;
        tick(1);
        chk("gpio_in_010",   dut.regs[11],  32'hA5A5_A5A2);

        tick(6);
        chk("ram_lw_s0",     dut.regs[16],  32'h1234_5678);
        chk("alu_subu_s1",   dut.regs[17],  32'h0);
        chk("alu_slt_s2",    dut.regs[18],  32'h1);
        chk("ram_word",      dut.dmem[16],  32'h1234_5678);

        tick(1);
        chk("loop_init_t5",  dut.regs[13],  32'd5);
        tick(15);
        chk("loop_exit_pc",  dut.pc,        32'h48);
        chk("loop_t5_zero",  dut.regs[13],  32'h0);
        tick(1);
        chk("jump_pc",       dut.pc,        32'h54);
        tick(1);
        chk("after_j_pc",    dut.pc,        32'h58);
        chk("after_j_t7",    dut.regs[15],  32'h77);
        chk("nop_t6",        dut.regs[14],  32'h0);
        tick(8);
        chk("spin_pc",       dut.pc,        32'h58);

        // Restart, then pull reset in the middle of the loop.
        rst_sync = 1'b0;
        tick(1);
        rst_sync = 1'b1;
        tick(20);
        chk("midrun_pc",     dut.pc,        32'h44);
        chk("midrun_t5",     dut.regs[13],  32'd3);
        rst_sync = 1'b0;
        tick(1);
        chk("midrst_pc",     dut.pc,        32'h0);
        chk("midrst_gpr",    gpr_nonzero(), 32'h0);
        chk("midrst_cfg",    dut.port_cfg,  32'hFFFF_FFFF);
        chk("midrst_pin_oe", dut.pin_oe,    32'h0);
        chk("midrst_ram",    dut.dmem[16],  32'h1234_5678);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
